vmem_beat_sequencer: RTL

//  Serialises one VLEN-bit vector load/store from the Memory stage into NBEATS

---
 rtl/vmem_beat_sequencer.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/vmem_beat_sequencer.sv
// vmem_beat_sequencer
//   Breaks one VLEN-bit vector load/store issued by the Memory stage into
//   NBEATS consecutive BEAT_W-bit beats on a req/ack memory bus. Load beats
//   are reassembled into ReadDataM. While the access is in flight StallM
//   freezes the pipeline.
//
// Ports
//   clk, rst      clock (rising edge), asynchronous active-high reset
//   MemReqM       M-stage instruction is a vector load/store
//   MemWriteM     1 = store, 0 = load (qualified by MemReqM)
//   AddrM         vector base byte address (must be VLEN/8-byte aligned)
//   WriteDataM    store data, beat k = WriteDataM[k*BEAT_W +: BEAT_W]
//   StallM        freeze F/D/E/M pipeline registers
//   ReadDataM     assembled load data, held until the next load writes it
//   ReadValidM    one-cycle pulse once a load has completed
//   MisalignErr   one-cycle pulse for an unaligned request (dropped as NOP)
//   mem_req/mem_we/mem_addr/mem_wdata   beat request towards memory
//   mem_ack/mem_rdata                   beat accept / read data from memory
module vmem_beat_sequencer #(
  parameter int VLEN   = 256,
  parameter int BEAT_W = 32,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              MemReqM,
  input  logic              MemWriteM,
  input  logic [ADDR_W-1:0] AddrM,
  input  logic [VLEN-1:0]   WriteDataM,
  output logic              StallM,
  output logic [VLEN-1:0]   ReadDataM,
  output logic              ReadValidM,
  output logic              MisalignErr,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [BEAT_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [BEAT_W-1:0] mem_rdata
);

  localparam int NBEATS     = VLEN / BEAT_W;
  localparam int CNT_W      = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam int ALIGN_W    = $clog2(VLEN / 8);
  localparam int BEAT_BYTES = BEAT_W / 8;

  localparam logic [CNT_W-1:0]  LAST_BEAT = CNT_W'(NBEATS - 1);
  localparam logic [ADDR_W-1:0] STRIDE    = ADDR_W'(BEAT_BYTES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BEAT = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state_r;
  state_t            nextState_s;
  logic [CNT_W-1:0]  cnt_r;
  logic [ADDR_W-1:0] baseAddr_r;
  logic [VLEN-1:0]   wdata_r;
  logic              we_r;
  logic [VLEN-1:0]   readData_r;

  logic              aligned_s;
  logic              start_s;
  logic              beatAck_s;

  assign aligned_s = (AddrM[ALIGN_W-1:0] == {ALIGN_W{1'b0}});
  assign start_s   = (state_r == IDLE) && MemReqM && aligned_s;
  assign beatAck_s = (state_r == BEAT) && mem_ack;
  assign ReadDataM = readData_r;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= nextState_s;
    end
  end

  // Latch the request on acceptance and step the beat counter on each ack
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r      <= {CNT_W{1'b0}};
      baseAddr_r <= {ADDR_W{1'b0}};
      wdata_r    <= {VLEN{1'b0}};
      we_r       <= 1'b0;
    end else if (start_s) begin
      cnt_r      <= {CNT_W{1'b0}};
      baseAddr_r <= AddrM;
      wdata_r    <= WriteDataM;
      we_r       <= MemWriteM;
    end else if (beatAck_s && (cnt_r != LAST_BEAT)) begin
      cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // Load reassembly: each acked read beat fills its own slice, the rest hold
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      readData_r <= {VLEN{1'b0}};
    end else if (beatAck_s && !we_r) begin
      readData_r[cnt_r*BEAT_W +: BEAT_W] <= mem_rdata;
    end
  end

  // Next-state logic and bus/pipeline handshake outputs
  always_comb begin
    nextState_s = state_r;
    StallM      = 1'b0;
    MisalignErr = 1'b0;
    ReadValidM  = 1'b0;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = {ADDR_W{1'b0}};
    mem_wdata   = {BEAT_W{1'b0}};
    case (state_r)
      IDLE: begin
        if (MemReqM) begin
          if (aligned_s) begin
            StallM      = 1'b1;
            nextState_s = BEAT;
          end else begin
            // Unaligned access retires as a NOP: flag it, no stall, no bus traffic
            MisalignErr = 1'b1;
            nextState_s = IDLE;
          end
        end else begin
          nextState_s = IDLE;
        end
      end
      BEAT: begin
        StallM   = 1'b1;
        mem_req  = 1'b1;
        mem_we   = we_r;
        // Address arithmetic wraps modulo 2^ADDR_W by construction
        mem_addr = baseAddr_r + (ADDR_W'(cnt_r) * STRIDE);
        if (we_r) begin
          mem_wdata = wdata_r[cnt_r*BEAT_W +: BEAT_W];
        end else begin
          mem_wdata = {BEAT_W{1'b0}};
        end
        if (mem_ack && (cnt_r == LAST_BEAT)) begin
          nextState_s = DONE;
        end else begin
          nextState_s = BEAT;
        end
      end
      DONE: begin
        // Pipeline advances this cycle; MemReqM still shows the same instr
        ReadValidM  = !we_r;
        nextState_s = IDLE;
      end
      default: begin
        nextState_s = IDLE;
      end
    endcase
  end

endmodule
